// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM state enum,
// datapath select encodings, ALU command decode and condition-code values.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXER   = 4'd6,
    ST_EXEI   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_LINK   = 4'd10
  } state_t;

  // Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_PC     = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_EXT  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Data-processing cmd field to ALU operation; unsupported commands add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    logic [1:0] r;
    case (cmd)
      4'b0100: r = ALU_ADD;
      4'b0010: r = ALU_SUB;
      4'b0000: r = ALU_AND;
      4'b1100: r = ALU_ORR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_mc_ctrl_if.sv
// Controller <-> datapath bundle. The master modport is the control unit
// (drives selects/enables), the slave modport is the datapath side
// (supplies instruction fields, ALU flags and the memory-ready strobe).
// mem_ready is a single-cycle completion strobe: an access in FETCH, MEMRD
// or MEMWR completes in exactly the cycle where mem_ready is high; the
// controller holds its address/enable outputs stable until then.
interface arm_mc_ctrl_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       mem_ready;

  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic       ir_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [1:0] alu_control;
  logic       link;

  // Debug visibility of the sequencer and the stored NZCV flags.
  arm_ctrl_pkg::state_t state_dbg;
  logic [3:0]           flags_dbg;

  modport master (
    input  op, funct, rd, cond, alu_flags, mem_ready,
    output pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
           alu_src_b, result_src, imm_src, reg_src, alu_control, link,
           state_dbg, flags_dbg
  );

  modport slave (
    output op, funct, rd, cond, alu_flags, mem_ready,
    input  pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
           alu_src_b, result_src, imm_src, reg_src, alu_control, link,
           state_dbg, flags_dbg
  );
endinterface

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition evaluation. cond_ex_o is computed from
// the stored flags; flags are loaded when the sequencer requests it and the
// instruction's own condition passes.
module arm_cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_upd_i,
  input  logic       cv_upd_i,
  output logic       cond_ex_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign flags_o = flags_q;

  // Standard ARM condition table against the stored flags.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z_f;
      COND_NE: cond_ex_o = ~z_f;
      COND_CS: cond_ex_o = c_f;
      COND_CC: cond_ex_o = ~c_f;
      COND_MI: cond_ex_o = n_f;
      COND_PL: cond_ex_o = ~n_f;
      COND_VS: cond_ex_o = v_f;
      COND_VC: cond_ex_o = ~v_f;
      COND_HI: cond_ex_o = c_f & ~z_f;
      COND_LS: cond_ex_o = ~c_f | z_f;
      COND_GE: cond_ex_o = (n_f == v_f);
      COND_LT: cond_ex_o = (n_f != v_f);
      COND_GT: cond_ex_o = ~z_f & (n_f == v_f);
      COND_LE: cond_ex_o = z_f | (n_f != v_f);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

  // Next flags: NZ on any flag-setting op, CV only for arithmetic ops.
  always_comb begin
    flags_d = flags_q;
    if (flag_upd_i && cond_ex_o) begin
      flags_d[3:2] = alu_flags_i[3:2];
      if (cv_upd_i) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle control unit for the 32-bit ARM core: sequences fetch, decode
// and execute, drives datapath selects/enables, gates writes with the
// condition result. Optional BL support is enabled by defining ARM_BL_EN
// (adds the LINK state which writes PC into R14 before branching).
module arm_mc_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  arm_mc_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic       adr_src, alu_src_a, link;
  logic [1:0] alu_src_b, result_src, alu_control;
  logic       ir_write_raw, fetch_pc, branch, reg_write_raw, mem_write_raw;
  logic       flag_upd, cv_upd, cond_ex;
  logic [3:0] flags;

  arm_cond_unit u_cond (
    .clk         (clk),
    .rst_n       (rst_n),
    .cond_i      (bus.cond),
    .alu_flags_i (bus.alu_flags),
    .flag_upd_i  (flag_upd),
    .cv_upd_i    (cv_upd),
    .cond_ex_o   (cond_ex),
    .flags_o     (flags)
  );

  // Only ADD/SUB produce meaningful carry/overflow.
  assign cv_upd = ~alu_control[1];

  // Next-state and Moore selects; raw enables before condition gating.
  always_comb begin
    state_d       = state_q;
    adr_src       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RD2;
    result_src    = RES_ALUOUT;
    alu_control   = ALU_ADD;
    link          = 1'b0;
    ir_write_raw  = 1'b0;
    fetch_pc      = 1'b0;
    branch        = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    flag_upd      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        if (bus.mem_ready) begin
          ir_write_raw = 1'b1;
          fetch_pc     = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        case (bus.op)
          OP_MEM: state_d = ST_MEMADR;
          OP_DP:  state_d = bus.funct[5] ? ST_EXEI : ST_EXER;
`ifdef ARM_BL_EN
          OP_BR:  state_d = bus.funct[4] ? ST_LINK : ST_BRANCH;
`else
          OP_BR:  state_d = ST_BRANCH;
`endif
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        alu_src_b = SRCB_EXT;
        state_d   = bus.funct[0] ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEMWR: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (bus.mem_ready) state_d = ST_FETCH;
      end
      ST_EXER, ST_EXEI: begin
        alu_src_b   = (state_q == ST_EXEI) ? SRCB_EXT : SRCB_RD2;
        alu_control = alu_decode(bus.funct[4:1]);
        flag_upd    = bus.funct[0];
        state_d     = ST_ALUWB;
      end
      ST_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_b  = SRCB_EXT;
        result_src = RES_ALURES;
        branch     = 1'b1;
        state_d    = ST_FETCH;
      end
`ifdef ARM_BL_EN
      ST_LINK: begin
        result_src    = RES_PC;
        link          = 1'b1;
        reg_write_raw = 1'b1;
        state_d       = ST_BRANCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Enables are killed combinationally by reset so nothing writes while it is
  // low. A register write to R15 also loads the PC, except for the link write
  // whose destination is forced to R14.
  assign bus.ir_write  = rst_n & ir_write_raw;
  assign bus.reg_write = rst_n & reg_write_raw & cond_ex;
  assign bus.mem_write = rst_n & mem_write_raw & cond_ex;
  assign bus.pc_write  = rst_n & (fetch_pc | (branch & cond_ex) |
                         (reg_write_raw & cond_ex & ~link & (bus.rd == 4'hF)));

  assign bus.adr_src     = adr_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.result_src  = result_src;
  assign bus.alu_control = alu_control;
  assign bus.link        = link;
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {bus.op == OP_MEM, bus.op == OP_BR};
  assign bus.state_dbg   = state_q;
  assign bus.flags_dbg   = flags;

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Directed bench for arm_mc_ctrl: a table of whole instructions run with
// mem_ready=1 (cycle count, write-enable counts, ALU op, resulting flags),
// followed by hand-written multi-cycle sequences for stalls, never-condition,
// reset mid-instruction and BL (ARM_BL_EN).
module tb_arm_mc_ctrl;
  import arm_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arm_mc_ctrl_if ifc ();

  arm_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [3:0] cyc;
    logic [3:0] rw;
    logic [3:0] mw;
    logic [3:0] pcw;
    logic [1:0] aluc;
    logic [3:0] flags;
  } vec_t;

  vec_t   vecs[17];
  state_t es[8];
  logic   mrs[8];

  // ---------------- driver ----------------
  task automatic drive_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] cond,
                             input logic [3:0] af);
    ifc.op        = op;
    ifc.funct     = funct;
    ifc.rd        = rd;
    ifc.cond      = cond;
    ifc.alu_flags = af;
  endtask

  // Runs one instruction from FETCH back to FETCH with mem_ready=1.
  task automatic run_instr(input vec_t v, output int cyc, output int rw,
                           output int mw, output int pcw, output logic [1:0] aluc);
    drive_instr(v.op, v.funct, v.rd, v.cond, v.alu_flags);
    ifc.mem_ready = 1'b1;
    cyc = 0; rw = 0; mw = 0; pcw = 0; aluc = 2'b00;
    do begin
      @(negedge clk);
      rw  += int'(ifc.reg_write);
      mw  += int'(ifc.mem_write);
      pcw += int'(ifc.pc_write);
      if (ifc.state_dbg == ST_EXER || ifc.state_dbg == ST_EXEI) aluc = ifc.alu_control;
      @(posedge clk); #1;
      cyc++;
    end while (ifc.state_dbg != ST_FETCH && cyc < 20);
  endtask

  int         r_cyc, r_rw, r_mw, r_pcw;
  logic [1:0] r_aluc;

  initial begin
    // op, funct, rd, cond, alu_flags | cyc, rw, mw, pcw, aluc, flags_after
    vecs[0]  = '{2'b00, 6'b001000, 4'd1,  4'hE, 4'b0000, 4'd4, 4'd1, 4'd0, 4'd1, 2'b00, 4'b0000}; // ADD
    vecs[1]  = '{2'b00, 6'b101001, 4'd2,  4'hE, 4'b1010, 4'd4, 4'd1, 4'd0, 4'd1, 2'b00, 4'b1010}; // ADDS imm
    vecs[2]  = '{2'b10, 6'b000000, 4'd0,  4'h4, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd2, 2'b00, 4'b1010}; // BMI taken
    vecs[3]  = '{2'b10, 6'b000000, 4'd0,  4'h5, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd1, 2'b00, 4'b1010}; // BPL not
    vecs[4]  = '{2'b01, 6'b000000, 4'd5,  4'h2, 4'b0000, 4'd4, 4'd0, 4'd1, 4'd1, 2'b00, 4'b1010}; // STRCS
    vecs[5]  = '{2'b01, 6'b000001, 4'd3,  4'h3, 4'b0000, 4'd5, 4'd0, 4'd0, 4'd1, 2'b00, 4'b1010}; // LDRCC skip
    vecs[6]  = '{2'b00, 6'b000001, 4'd4,  4'hE, 4'b0111, 4'd4, 4'd1, 4'd0, 4'd1, 2'b10, 4'b0110}; // ANDS
    vecs[7]  = '{2'b10, 6'b000000, 4'd0,  4'h0, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd2, 2'b00, 4'b0110}; // BEQ taken
    vecs[8]  = '{2'b10, 6'b000000, 4'd0,  4'h1, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd1, 2'b00, 4'b0110}; // BNE not
    vecs[9]  = '{2'b00, 6'b001000, 4'd15, 4'hE, 4'b0000, 4'd4, 4'd1, 4'd0, 4'd2, 2'b00, 4'b0110}; // ADD PC
    vecs[10] = '{2'b00, 6'b000101, 4'd6,  4'h8, 4'b1001, 4'd4, 4'd0, 4'd0, 4'd1, 2'b01, 4'b0110}; // SUBSHI skip
    vecs[11] = '{2'b00, 6'b000101, 4'd6,  4'hE, 4'b1001, 4'd4, 4'd1, 4'd0, 4'd1, 2'b01, 4'b1001}; // SUBS
    vecs[12] = '{2'b10, 6'b000000, 4'd0,  4'hA, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd2, 2'b00, 4'b1001}; // BGE taken
    vecs[13] = '{2'b10, 6'b000000, 4'd0,  4'hB, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd1, 2'b00, 4'b1001}; // BLT not
    vecs[14] = '{2'b11, 6'b000000, 4'd0,  4'hE, 4'b0000, 4'd2, 4'd0, 4'd0, 4'd1, 2'b00, 4'b1001}; // illegal
    vecs[15] = '{2'b00, 6'b011001, 4'd7,  4'hE, 4'b0111, 4'd4, 4'd1, 4'd0, 4'd1, 2'b11, 4'b0101}; // ORRS
    vecs[16] = '{2'b10, 6'b000000, 4'd0,  4'hF, 4'b0000, 4'd3, 4'd0, 4'd0, 4'd1, 2'b00, 4'b0101}; // B never

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive_instr(2'b01, 6'b000000, 4'd15, 4'hE, 4'b1111);
    ifc.mem_ready = 1'b1;
    @(negedge clk);
    check("rst_state",      ifc.state_dbg,   ST_FETCH);
    check("rst_flags",      ifc.flags_dbg,   4'b0000);
    check("rst_ir_write",   ifc.ir_write,    1'b0);
    check("rst_pc_write",   ifc.pc_write,    1'b0);
    check("rst_reg_write",  ifc.reg_write,   1'b0);
    check("rst_mem_write",  ifc.mem_write,   1'b0);
    check("rst_adr_src",    ifc.adr_src,     1'b0);
    check("rst_alu_src_a",  ifc.alu_src_a,   1'b1);
    check("rst_alu_src_b",  ifc.alu_src_b,   SRCB_FOUR);
    check("rst_result_src", ifc.result_src,  RES_ALURES);
    check("rst_alu_ctrl",   ifc.alu_control, ALU_ADD);
    check("rst_link",       ifc.link,        1'b0);
    check("rst_imm_src",    ifc.imm_src,     IMM_12);
    check("rst_reg_src",    ifc.reg_src,     2'b10);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- table of instructions ----------------
    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i], r_cyc, r_rw, r_mw, r_pcw, r_aluc);
      check($sformatf("v%0d_cycles", i),    r_cyc,         vecs[i].cyc);
      check($sformatf("v%0d_reg_write", i), r_rw,          vecs[i].rw);
      check($sformatf("v%0d_mem_write", i), r_mw,          vecs[i].mw);
      check($sformatf("v%0d_pc_write", i),  r_pcw,         vecs[i].pcw);
      check($sformatf("v%0d_flags", i),     ifc.flags_dbg, vecs[i].flags);
      if (vecs[i].op == OP_DP) check($sformatf("v%0d_alu_ctrl", i), r_aluc, vecs[i].aluc);
    end

    // ---------------- LDR with two stall cycles in MEMRD ----------------
    drive_instr(2'b01, 6'b000001, 4'd4, 4'hE, 4'b0000);
    es[0] = ST_FETCH;  es[1] = ST_DECODE; es[2] = ST_MEMADR; es[3] = ST_MEMRD;
    es[4] = ST_MEMRD;  es[5] = ST_MEMRD;  es[6] = ST_MEMWB;
    mrs[0] = 1; mrs[1] = 1; mrs[2] = 1; mrs[3] = 0; mrs[4] = 0; mrs[5] = 1; mrs[6] = 1;
    for (int c = 0; c < 7; c++) begin
      ifc.mem_ready = mrs[c];
      @(negedge clk);
      check($sformatf("ldr_state_c%0d", c), ifc.state_dbg, es[c]);
      check($sformatf("ldr_reg_write_c%0d", c), ifc.reg_write, (c == 6));
      if (es[c] == ST_MEMRD) check($sformatf("ldr_adr_src_c%0d", c), ifc.adr_src, 1'b1);
      if (c == 6) check("ldr_result_src", ifc.result_src, RES_DATA);
      @(posedge clk); #1;
    end
    check("ldr_back_fetch", ifc.state_dbg, ST_FETCH);

    // ---------------- STR never, fetch stall and MEMWR stall ----------------
    drive_instr(2'b01, 6'b000000, 4'd2, 4'hF, 4'b0000);
    es[0] = ST_FETCH;  es[1] = ST_FETCH;  es[2] = ST_DECODE;
    es[3] = ST_MEMADR; es[4] = ST_MEMWR;  es[5] = ST_MEMWR;
    mrs[0] = 0; mrs[1] = 1; mrs[2] = 1; mrs[3] = 1; mrs[4] = 0; mrs[5] = 1;
    for (int c = 0; c < 6; c++) begin
      ifc.mem_ready = mrs[c];
      @(negedge clk);
      check($sformatf("strnv_state_c%0d", c), ifc.state_dbg, es[c]);
      check($sformatf("strnv_mem_write_c%0d", c), ifc.mem_write, 1'b0);
      if (c < 2) check($sformatf("strnv_ir_write_c%0d", c), ifc.ir_write, (c == 1));
      @(posedge clk); #1;
    end
    check("strnv_back_fetch", ifc.state_dbg, ST_FETCH);

    // ---------------- reset during MEMWR ----------------
    drive_instr(2'b01, 6'b000000, 4'd2, 4'hE, 4'b0000);
    mrs[0] = 1; mrs[1] = 1; mrs[2] = 1; mrs[3] = 0;
    for (int c = 0; c < 4; c++) begin
      ifc.mem_ready = mrs[c];
      @(negedge clk);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    check("rstmid_pre_state",     ifc.state_dbg, ST_MEMWR);
    check("rstmid_pre_mem_write", ifc.mem_write, 1'b1);
    check("rstmid_pre_flags",     ifc.flags_dbg, 4'b0101);
    #1 rst_n = 1'b0;
    ifc.mem_ready = 1'b1;
    #1;
    check("rstmid_mem_write", ifc.mem_write, 1'b0);
    check("rstmid_state",     ifc.state_dbg, ST_FETCH);
    check("rstmid_flags",     ifc.flags_dbg, 4'b0000);
    check("rstmid_pc_write",  ifc.pc_write,  1'b0);
    @(posedge clk); #1;
    ifc.mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrel_state",     ifc.state_dbg, ST_FETCH);
    check("rstrel_mem_write", ifc.mem_write, 1'b0);
    check("rstrel_ir_write",  ifc.ir_write,  1'b0);
    @(posedge clk); #1;
    check("rstrel_hold",      ifc.state_dbg, ST_FETCH);

    // ---------------- BL ----------------
    drive_instr(2'b10, 6'b010000, 4'd0, 4'hE, 4'b0000);
    ifc.mem_ready = 1'b1;
`ifdef ARM_BL_EN
    es[0] = ST_FETCH; es[1] = ST_DECODE; es[2] = ST_LINK; es[3] = ST_BRANCH;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bl_state_c%0d", c), ifc.state_dbg, es[c]);
      check($sformatf("bl_link_c%0d", c), ifc.link, (c == 2));
      check($sformatf("bl_reg_write_c%0d", c), ifc.reg_write, (c == 2));
      if (c == 2) check("bl_result_src", ifc.result_src, RES_PC);
      if (c == 3) check("bl_pc_write", ifc.pc_write, 1'b1);
      @(posedge clk); #1;
    end
    check("bl_back_fetch", ifc.state_dbg, ST_FETCH);
`else
    es[0] = ST_FETCH; es[1] = ST_DECODE; es[2] = ST_BRANCH;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bnolink_state_c%0d", c), ifc.state_dbg, es[c]);
      check($sformatf("bnolink_link_c%0d", c), ifc.link, 1'b0);
      check($sformatf("bnolink_reg_write_c%0d", c), ifc.reg_write, 1'b0);
      if (c == 2) check("bnolink_pc_write", ifc.pc_write, 1'b1);
      @(posedge clk); #1;
    end
    check("bnolink_back_fetch", ifc.state_dbg, ST_FETCH);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arm_mc_ctrl.md
# arm_mc_ctrl

Multicycle control unit for the 32-bit ARM core. It sequences the shared datapath (PC/ALU/memory port, register file, immediate extender) through fetch, decode and execute states, and drives every mux select and write enable. It also decodes the ALU command, selects the immediate-extension mode, evaluates the condition field against a stored NZCV flag register, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  2  Instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal
- funct  in  6  Instr[25:20]; [5] I-bit, [4:1] cmd, [0] S/L-store
- rd  in  4  Instr[15:12]
- cond  in  4  Instr[31:28]
- alu_flags  in  4  NZCV from the ALU, current cycle
- mem_ready  in  1  memory completes the access this cycle
- pc_write, mem_write, reg_write, ir_write  out  1  write enables, condition-gated where stated
- adr_src  out  1  0 = PC, 1 = ALUOut
- alu_src_a  out  1  0 = RD1, 1 = PC
- alu_src_b  out  2  00 RD2, 01 ExtImm, 10 constant 4
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 PC
- imm_src  out  2  equals op: 00 imm8, 01 imm12, 10 imm24
- reg_src  out  2  [0] = (op==10), [1] = (op==01)
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- link  out  1  forces register write address to R14

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH, LINK (LINK only with macro).
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, ADD. Held until mem_ready=1; in that cycle ir_write=1 and pc_write=1 (unconditional), then DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10, ADD (ALUOut = PC+8). Next: op=01 → MEMADR; op=00 → EXEI if funct[5] else EXER; op=10 → BRANCH (LINK first if macro and funct[4]); op=11 → FETCH, no writes.
- MEMADR: alu_src_a=0, alu_src_b=01, ADD; funct[0] ? MEMRD : MEMWR.
- MEMRD: adr_src=1; hold until mem_ready, then MEMWB. MEMWB: result_src=01, reg_write.
- MEMWR: adr_src=1, mem_write asserted every cycle in state; leave to FETCH when mem_ready=1.
- EXER/EXEI: alu_src_a=0, alu_src_b 00/01, alu_control from cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, others ADD. Then ALUWB: result_src=00, reg_write.
- BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, ADD, branch write.
- Condition gating: cond_ex from stored flags (standard ARM table, 1110 always, 1111 never). reg_write, mem_write, state-driven pc_write are ANDed with cond_ex. rd==15 with reg write also asserts pc_write.
- Flags: updated at EXER/EXEI exit when cond_ex and funct[0]; NZ always, CV only for ADD/SUB.

## Timing
- Reset: state FETCH, flags 0000; all write enables 0 while rst_n low; selects take FETCH values.
- Latency with mem_ready=1: B 3, DP 4, STR 4, LDR 5, BL 4 cycles; each low mem_ready cycle in FETCH/MEMRD/MEMWR adds one.
- Reset mid-instruction: abort immediately, no partial write after deassertion.
- Outputs are Moore except the mem_ready qualification and cond_ex gating (same-cycle).

## Configuration
- ARM_BL_EN defined: DECODE with op=10, funct[4]=1 goes to LINK: result_src=11, link=1, reg_write (cond-gated), then BRANCH.
- Undefined: L bit ignored, LINK absent, link tied 0.

## Structure
- arm_ctrl_pkg: state enum, alu_control/result_src/alu_src_b/imm_src encodings, cond-code constants.
- Sub-module arm_cond_unit: flag register, flag update, cond_ex evaluation.

## Test plan
- ADD R1,R2,R3 (op 00, cmd 0100, I=0, cond 1110), mem_ready=1 → FETCH,DECODE,EXER,ALUWB; reg_write=1 in cycle 4, alu_control=00.
- LDR with mem_ready low 2 cycles in MEMRD → 7 cycles total, reg_write only in MEMWB with result_src=01.
- SUBS giving zero then BEQ → flags Z=1, BRANCH asserts pc_write=1; BNE → pc_write=0, returns to FETCH.
- STR cond 1111 → MEMWR with mem_write=0 throughout; op=11 → DECODE to FETCH, no write enables.
- rst_n low during MEMWR → mem_write drops same cycle; after release FETCH, flags 0000.
- ARM_BL_EN, BL → LINK with link=1, result_src=11, reg_write=1, then BRANCH; 4 cycles.
